stack_sequencer: RTL
====================

// Module: stack_sequencer
// PURPOSE
//  Multi-cycle controller in front of the stack pointer register. Accepts PUSH/POP/CALL/RET/INT/RTI.
//  Sequences 16-bit stack memory accesses (32-bit PC = 2 words, flags = 1 word).
//  Produces the SP update (sp_next/sp_we) consumed by the SP register and stalls the pipeline while busy.
//  Stack is empty-descending: SP addresses the next free word; push writes M[SP], then SP-1.
// PARAMETERS
//  ADDR_W     32    stack/memory address width
//  DATA_W     16    memory word width
//  FLAG_W     3     CCR flag width (zero-extended to DATA_W when pushed)
//  STACK_TOP  2047  highest stack address (SP value when empty)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  reset      in   1       asynchronous, active-low reset
//  op_valid   in   1       operation request
//  op_ready   out  1       high only in IDLE; op accepted when op_valid & op_ready
//  op_code    in   3       0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6-7 reserved (NOP)
//  push_data  in   DATA_W  word for PUSH, sampled at accept
//  pc_in      in   32      return PC for CALL/INT, sampled at accept
//  flags_in   in   FLAG_W  flags for INT, sampled at accept
//  sp_in      in   ADDR_W  current SP, sampled at accept into internal sp_cur
//  sp_next    out  ADDR_W  new SP value, valid when sp_we
//  sp_we      out  1       one-cycle pulse per word; SP register loads sp_next
//  mem_addr   out  ADDR_W  stack memory address
//  mem_wdata  out  DATA_W  write data
//  mem_we     out  1       write strobe
//  mem_re     out  1       read strobe; mem_rdata valid on the following cycle
//  mem_rdata  in   DATA_W  read data
//  busy       out  1       stall request; high in every non-IDLE state
//  done       out  1       one-cycle pulse on op completion
//  pop_data   out  DATA_W  POP result, valid with done
//  pc_out     out  32      restored PC, valid with pc_load
//  pc_load    out  1       pulse with done for RET/RTI
//  flags_out  out  FLAG_W  restored flags, valid with flags_load
//  flags_load out  1       pulse with done for RTI
//  stack_err  out  1       one-cycle pulse on bound violation (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (any time, incl. mid-op): state IDLE; all outputs 0 except op_ready=1.
//    No further mem/SP strobes; a partially executed op is abandoned.
//  - States: IDLE, WR, RD_REQ, RD_CAP, DONE. Word counter cnt sized to 0..2.
//  - Word order:
//      PUSH: [data].  CALL: [PC[31:16], PC[15:0]].  INT: [flags, PC[31:16], PC[15:0]].
//      POP: [data].   RET: [PC[15:0], PC[31:16]].   RTI: [PC[15:0], PC[31:16], flags].
//  - Accept: IDLE->WR (push ops) or RD_REQ (pop ops). Reserved op -> DONE directly, no strobes.
//  - WR, one cycle per word: mem_we=1, mem_addr=sp_cur, sp_next=sp_cur-1, sp_we=1; sp_cur<=sp_cur-1.
//    After the last word -> DONE.
//  - RD_REQ: mem_re=1, mem_addr=sp_cur+1, sp_next=sp_cur+1, sp_we=1; sp_cur<=sp_cur+1; -> RD_CAP.
//  - RD_CAP: capture mem_rdata into the word's destination; -> RD_REQ if words remain, else DONE.
//  - DONE: done=1 plus pc_load/flags_load per op; -> IDLE.
//  - Latency, accept edge to done: n-word push = n+1 cycles (PUSH 2, CALL 3, INT 4);
//    n-word pop = 2n+1 cycles (POP 3, RET 5, RTI 7).
//  - op_valid while busy is ignored, not queued. sp_in is ignored after accept.
//  - SP arithmetic is modulo 2^ADDR_W; flags use the low FLAG_W bits of the popped word.
//  - pop_data/pc_out/flags_out hold their last value until overwritten.
// CONFIGURATION
//  STACK_BOUNDS_CHECK_EN defined:
//    - Before each word, a push with sp_cur==0 or a pop with sp_cur>=STACK_TOP is a violation.
//    - Violation: suppress that word's strobes; stack_err=1 for that cycle; -> IDLE (no done).
//    - Earlier words of the op remain committed.
//  Not defined: no checks, addresses wrap; stack_err tied 0.
// TESTING
//  1. PUSH 0xBEEF, sp_in=2047 -> M[2047]=0xBEEF; sp_next=2046; done 2 cycles after accept.
//  2. CALL pc=0x0001_2345, sp_in=2047 -> M[2047]=0x0001, M[2046]=0x2345; final SP 2045; done at +3.
//  3. RET from SP=2045 after test 2 -> pc_out=0x0001_2345, pc_load with done at +5; SP 2047.
//  4. INT pc=0x0000_0100, flags=3'b101 from 2047, then RTI -> M[2047]=0x0005;
//     RTI restores pc=0x100, flags=101, SP 2047.
//  5. Reset low during 2nd WR cycle of CALL -> outputs 0 immediately, op_ready=1, no done.
//     Next op runs normally.
//  6. STACK_BOUNDS_CHECK_EN: POP at sp_in=2047 -> stack_err pulse, no mem_re, no sp_we, no done.
//     Without the macro: mem_addr=2048.

Source files
------------

// File: rtl/stack_sequencer.sv
// Multi-cycle stack access sequencer for PUSH/POP/CALL/RET/INT/RTI, driving the SP register and stack memory.
// Optional bound checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int FLAG_W    = 3,
    parameter int STACK_TOP = 2047
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] push_data,
    input  logic [31:0]       pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [ADDR_W-1:0] sp_in,
    output logic [ADDR_W-1:0] sp_next,
    output logic              sp_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] pop_data,
    output logic [31:0]       pc_out,
    output logic              pc_load,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_load,
    output logic              stack_err
);

    localparam int PC_W = 32;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state, nstate;
    logic [1:0]        cnt;
    logic [2:0]        op_r;
    logic [ADDR_W-1:0] sp_cur;
    logic [DATA_W-1:0] push_data_r;
    logic [PC_W-1:0]   pc_r;
    logic [FLAG_W-1:0] flags_r;
    logic              viol;
    logic              last;

    // Index of the final word for each op (words are counted from 0).
    function automatic logic [1:0] last_word(input logic [2:0] op);
        case (op)
            OP_CALL, OP_RET: last_word = 2'd1;
            OP_INT, OP_RTI:  last_word = 2'd2;
            default:         last_word = 2'd0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] push_word(
        input logic [2:0]        op,
        input logic [1:0]        idx,
        input logic [DATA_W-1:0] data,
        input logic [PC_W-1:0]   pc,
        input logic [FLAG_W-1:0] flags
    );
        case (op)
            OP_CALL: push_word = (idx == 2'd0) ? DATA_W'(pc[31:16]) : DATA_W'(pc[15:0]);
            OP_INT: begin
                case (idx)
                    2'd0:    push_word = DATA_W'(flags);
                    2'd1:    push_word = DATA_W'(pc[31:16]);
                    default: push_word = DATA_W'(pc[15:0]);
                endcase
            end
            default: push_word = data;
        endcase
    endfunction

    assign last = (cnt == last_word(op_r));

    always_comb begin
        nstate     = state;
        op_ready   = 1'b0;
        busy       = 1'b1;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sp_we      = 1'b0;
        sp_next    = '0;
        done       = 1'b0;
        pc_load    = 1'b0;
        flags_load = 1'b0;
        stack_err  = 1'b0;
        viol       = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op_code)
                        OP_PUSH, OP_CALL, OP_INT: nstate = WR;
                        OP_POP, OP_RET, OP_RTI:   nstate = RD_REQ;
                        default:                  nstate = DONE;
                    endcase
                end
            end
            WR: begin
                viol = BOUNDS_EN && (sp_cur == '0);
                if (viol) begin
                    stack_err = 1'b1;
                    nstate    = IDLE;
                end else begin
                    mem_we    = 1'b1;
                    mem_addr  = sp_cur;
                    mem_wdata = push_word(op_r, cnt, push_data_r, pc_r, flags_r);
                    sp_we     = 1'b1;
                    sp_next   = sp_cur - 1'b1;
                    if (last) nstate = DONE;
                end
            end
            RD_REQ: begin
                viol = BOUNDS_EN && (sp_cur >= ADDR_W'(STACK_TOP));
                if (viol) begin
                    stack_err = 1'b1;
                    nstate    = IDLE;
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = sp_cur + 1'b1;
                    sp_we    = 1'b1;
                    sp_next  = sp_cur + 1'b1;
                    nstate   = RD_CAP;
                end
            end
            RD_CAP: nstate = last ? DONE : RD_REQ;
            DONE: begin
                done       = 1'b1;
                pc_load    = (op_r == OP_RET) || (op_r == OP_RTI);
                flags_load = (op_r == OP_RTI);
                nstate     = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= '0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_r <= op_code;
                        cnt  <= '0;
                    end
                end
                WR:      if (!viol && !last) cnt <= cnt + 1'b1;
                RD_CAP:  if (!last) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Operand and SP working copies; outputs are gated by state so these need no reset.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (op_valid) begin
                    sp_cur      <= sp_in;
                    push_data_r <= push_data;
                    pc_r        <= pc_in;
                    flags_r     <= flags_in;
                end
            end
            WR:      if (!viol) sp_cur <= sp_cur - 1'b1;
            RD_REQ:  if (!viol) sp_cur <= sp_cur + 1'b1;
            default: ;
        endcase
    end

    // Popped words land directly in their destination registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_data  <= '0;
            pc_out    <= '0;
            flags_out <= '0;
        end else if (state == RD_CAP) begin
            case (op_r)
                OP_POP: pop_data <= mem_rdata;
                OP_RET, OP_RTI: begin
                    case (cnt)
                        2'd0:    pc_out[DATA_W-1:0]    <= mem_rdata;
                        2'd1:    pc_out[PC_W-1:DATA_W] <= mem_rdata[PC_W-DATA_W-1:0];
                        default: flags_out             <= mem_rdata[FLAG_W-1:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
